// File: rtl/tinker_mem_responder.sv
// Memory-side responder for the Tinker core: one request at a time, byte-serial transfer
// against an internal big-endian byte store, response returned over a valid/ready handshake.
module tinker_mem_responder #(
    parameter int unsigned MEM_BYTES = 524288,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t           state;
    logic             we_q;
    logic             size_q;
    logic [IDX_W-1:0] base;
    logic [63:0]      wbuf;
    logic [2:0]       cnt;

    logic [7:0] mem [MEM_BYTES];

    logic [ADDR_W:0]  req_end;
    logic             req_oor;
    logic [IDX_W-1:0] idx;
    logic             last;

    // Range check in ADDR_W+1 bits so a request near the top of the address space cannot wrap.
    assign req_end   = {1'b0, req_addr} + (req_size ? (ADDR_W+1)'(8) : (ADDR_W+1)'(4));
    assign req_oor   = req_end > (ADDR_W+1)'(MEM_BYTES);
    assign idx       = base + IDX_W'(cnt);
    assign last      = cnt == (size_q ? 3'd7 : 3'd3);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            cnt        <= 3'd0;
            we_q       <= 1'b0;
            size_q     <= 1'b0;
            base       <= '0;
            wbuf       <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        base       <= req_addr[IDX_W-1:0];
                        // Left-align the store data so the next byte to write is always [63:56].
                        wbuf       <= req_size ? req_wdata : {req_wdata[31:0], 32'd0};
                        resp_rdata <= 64'd0;
                        cnt        <= 3'd0;
                        if (req_oor) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_err <= 1'b0;
                            state    <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!we_q) begin
                        resp_rdata <= {resp_rdata[55:0], mem[idx]};
                    end
                    wbuf <= {wbuf[55:0], 8'd0};
                    cnt  <= cnt + 3'd1;
                    if (last) begin
                        cnt        <= 3'd0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is never reset; an async reset mid-store leaves state IDLE so later bytes are skipped.
    always_ff @(posedge clk) begin
        if (state == XFER && we_q) begin
            mem[idx] <= wbuf[63:56];
        end
    end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Randomised self-checking bench for tinker_mem_responder against a byte-array reference model.
module tb_tinker_mem_responder;

    localparam int unsigned MEM_BYTES = 524288;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [int unsigned];

    tinker_mem_responder #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for its response and handshake it; returns edges from accept.
    task automatic transact(input logic we, input logic size, input logic [31:0] addr,
                            input logic [63:0] wdata, output logic [63:0] rdata,
                            output logic err, output int lat);
        int guard = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rdata      = resp_rdata;
        err        = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic run_op(input logic we, input logic size, input logic [31:0] addr,
                          input logic [63:0] wdata, input string tag);
        int unsigned n = size ? 8 : 4;
        logic [63:0] end_a = {32'd0, addr} + 64'(n);
        logic        exp_err = end_a > 64'(MEM_BYTES);
        logic [63:0] exp_rd = 64'd0;
        logic [63:0] sh;
        logic [63:0] rd;
        logic        er;
        int          lat;
        if (!exp_err && !we) begin
            for (int unsigned i = 0; i < n; i++) begin
                exp_rd = {exp_rd[55:0], ref_mem.exists(addr + i) ? ref_mem[addr + i] : 8'h00};
            end
        end
        transact(we, size, addr, wdata, rd, er, lat);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, 64'(er), 64'(exp_err));
        check({tag, ".lat"}, 64'(lat), exp_err ? 64'd1 : 64'(n + 1));
        if (!exp_err && we) begin
            for (int unsigned i = 0; i < n; i++) begin
                sh = wdata >> (8 * (n - 1 - i));
                ref_mem[addr + i] = sh[7:0];
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] held;
        int          guard;
        int          lat;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;
        #12;
        reset = 1'b0;
        #1;
        check("rst.resp_valid", 64'(resp_valid), 64'd0);
        check("rst.resp_rdata", resp_rdata, 64'd0);
        check("rst.resp_err", 64'(resp_err), 64'd0);
        check("rst.req_ready", 64'(req_ready), 64'd1);
        tick();

        // Fetch of a preloaded word, then an 8-byte store/load round trip.
        run_op(1'b1, 1'b0, 32'h2000, 64'h0000_0000_1234_5678, "pre");
        run_op(1'b0, 1'b0, 32'h2000, 64'd0, "fetch");
        run_op(1'b1, 1'b1, 32'h100, 64'h0102_0304_0506_0708, "st8");
        run_op(1'b0, 1'b1, 32'h100, 64'd0, "ld8");

        // Top-of-memory boundaries, including a request that would wrap 32 bits.
        run_op(1'b1, 1'b1, 32'h7FFF0, 64'h1122_3344_5566_7788, "topfill0");
        run_op(1'b1, 1'b1, 32'h7FFF8, 64'h99AA_BBCC_DDEE_FF00, "topfill1");
        run_op(1'b0, 1'b1, 32'h7FFF9, 64'd0, "oor8");
        run_op(1'b0, 1'b1, 32'h7FFF8, 64'd0, "edge8");
        run_op(1'b0, 1'b0, 32'h7FFFC, 64'd0, "edge4");
        run_op(1'b1, 1'b0, 32'h7FFFD, 64'hDEAD_BEEF, "oor4st");
        run_op(1'b0, 1'b0, 32'hFFFF_FFFC, 64'd0, "wrap");

        // Back-pressure followed by a queued request that must wait for the handshake.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 1'b1;
        req_addr  = 32'h100;
        tick();
        req_size = 1'b0;
        req_addr = 32'h2000;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("bp.lat", 64'(guard + 1), 64'd9);
        held = resp_rdata;
        check("bp.data", held, 64'h0102_0304_0506_0708);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp.valid", 64'(resp_valid), 64'd1);
            check("bp.stable", resp_rdata, held);
            check("bp.req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        check("b2b.valid_drop", 64'(resp_valid), 64'd0);
        check("b2b.ready_back", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("b2b.accepted", 64'(req_ready), 64'd0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b.lat", 64'(lat), 64'd5);
        check("b2b.data", resp_rdata, 64'h0000_0000_1234_5678);
        tick();
        resp_ready = 1'b0;

        // Reset during a store after three bytes have been written.
        run_op(1'b1, 1'b1, 32'h200, 64'd0, "zero200");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 1'b1;
        req_addr  = 32'h200;
        req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midrst.resp_valid", 64'(resp_valid), 64'd0);
        check("midrst.req_ready", 64'(req_ready), 64'd1);
        for (int unsigned i = 0; i < 3; i++) ref_mem[32'h200 + i] = 8'hAA;
        tick();
        run_op(1'b0, 1'b1, 32'h200, 64'd0, "midrst.ld");

        // Random traffic over a prefilled window plus the top-of-memory region.
        for (int unsigned i = 0; i < 32; i++) begin
            run_op(1'b1, 1'b1, 32'h1000 + 8 * i, {$urandom(), $urandom()}, "fill");
        end
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1, 2:    a = 32'h7FFF0 + $urandom_range(0, 15);
                default: a = 32'h1000 + $urandom_range(0, 248);
            endcase
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                   {$urandom(), $urandom()}, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
